// File: rtl/enc_pkg.sv
// Package enc_pkg: mnemonic codes, MIPS opcode/funct values and word-packing
// helpers shared by the instruction encoder and the core's decoder.
package enc_pkg;

    // Mnemonic codes accepted on req_op; codes 11..15 are illegal.
    typedef enum logic [3:0] {
        OP_LW   = 4'd0,
        OP_SW   = 4'd1,
        OP_J    = 4'd2,
        OP_JAL  = 4'd3,
        OP_BNE  = 4'd4,
        OP_ADDI = 4'd5,
        OP_XORI = 4'd6,
        OP_ADD  = 4'd7,
        OP_SUB  = 4'd8,
        OP_SLT  = 4'd9,
        OP_JR   = 4'd10
    } enc_op_t;

    // Primary opcodes (instruction bits 31:26).
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_XORI  = 6'h0e;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;

    // R-type function codes (instruction bits 5:0).
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;

    // R-type word: opcode 0, shamt always 0.
    function automatic logic [31:0] pack_r(input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd,
                                           input logic [5:0] fn);
        return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    // I-type word: {opcode, rs, rt, imm16}.
    function automatic logic [31:0] pack_i(input logic [5:0]  opc,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    // J-type word: {opcode, target26}.
    function automatic logic [31:0] pack_j(input logic [5:0]  opc,
                                           input logic [25:0] tgt);
        return {opc, tgt};
    endfunction

endpackage

// File: rtl/enc_out_buf.sv
// enc_out_buf: 2-entry in-order FIFO of {address, instruction word} pairs.
// The head entry drives the imem write port directly, so its contents stay
// stable for as long as the entry is not popped. A push and a pop in the same
// cycle are legal even when full: the pop frees the slot the push lands in.
module enc_out_buf #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic [31:0]   i_push_data,
    input  logic          i_pop,
    output logic [AW-1:0] o_head_addr,
    output logic [31:0]   o_head_data,
    output logic          o_full,
    output logic          o_empty
);

    logic [AW-1:0] r_addr [2];
    logic [31:0]   r_data [2];
    logic          r_rd_idx;
    logic          r_wr_idx;
    logic [1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full      = (r_count == 2'd2);
    assign o_empty     = (r_count == 2'd0);
    assign o_head_addr = r_addr[r_rd_idx];
    assign o_head_data = r_data[r_rd_idx];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, read/write indices and occupancy; reset drops every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr[0] <= '0;
            r_addr[1] <= '0;
            r_data[0] <= 32'h0000_0000;
            r_data[1] <= 32'h0000_0000;
            r_rd_idx  <= 1'b0;
            r_wr_idx  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_addr[r_wr_idx] <= i_push_addr;
                r_data[r_wr_idx] <= i_push_data;
                r_wr_idx         <= ~r_wr_idx;
            end
            if (w_do_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs mnemonic+field requests into 32-bit MIPS-subset words
// and writes them to consecutive instruction-memory word addresses.
// Optional feature: define ENC_BRANCH_REL_EN to treat the BNE operand as an
// absolute word address and encode it as a PC-relative offset.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_valid,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   instr_count,
    output logic              err_illegal,
    output logic              addr_wrap
);

    localparam logic [ADDR_W-1:0] PTR_RESET = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   CNT_MAX   = {(ADDR_W+1){1'b1}};

    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_err_illegal;
    logic              r_addr_wrap;
    logic [ADDR_W:0]   r_instr_count;

    logic              w_buf_full;
    logic              w_buf_empty;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_legal;
    logic [31:0]       w_word;
    logic [15:0]       w_bne_imm;

    assign req_ready   = !w_buf_full && !base_valid;
    assign w_accept    = req_valid && req_ready;
    assign w_push      = w_accept && w_legal;
    assign imem_we     = !w_buf_empty;
    assign w_pop       = imem_we && imem_ready;

    assign instr_count = r_instr_count;
    assign err_illegal = r_err_illegal;
    assign addr_wrap   = r_addr_wrap;

`ifdef ENC_BRANCH_REL_EN
    logic [ADDR_W-1:0] w_rel_off;

    // Offset from the instruction after the branch, in ADDR_W-bit arithmetic.
    always_comb begin
        w_rel_off = ADDR_W'(req_imm) - (r_wr_ptr + ADDR_W'(1));
        w_bne_imm = 16'($signed(w_rel_off));
    end
`else
    // BNE operand goes into the immediate field untouched.
    always_comb begin
        w_bne_imm = req_imm;
    end
`endif

    // Encode the requested mnemonic into an instruction word and flag legality.
    always_comb begin
        w_word  = 32'h0000_0000;
        w_legal = 1'b1;
        case (req_op)
            OP_LW:   w_word = pack_i(OPC_LW,   req_rs, req_rt, req_imm);
            OP_SW:   w_word = pack_i(OPC_SW,   req_rs, req_rt, req_imm);
            OP_J:    w_word = pack_j(OPC_J,    req_target);
            OP_JAL:  w_word = pack_j(OPC_JAL,  req_target);
            OP_BNE:  w_word = pack_i(OPC_BNE,  req_rs, req_rt, w_bne_imm);
            OP_ADDI: w_word = pack_i(OPC_ADDI, req_rs, req_rt, req_imm);
            OP_XORI: w_word = pack_i(OPC_XORI, req_rs, req_rt, req_imm);
            OP_ADD:  w_word = pack_r(req_rs, req_rt, req_rd, FN_ADD);
            OP_SUB:  w_word = pack_r(req_rs, req_rt, req_rd, FN_SUB);
            OP_SLT:  w_word = pack_r(req_rs, req_rt, req_rd, FN_SLT);
            OP_JR:   w_word = pack_r(req_rs, 5'd0, 5'd0, FN_JR);
            default: begin
                w_word  = 32'h0000_0000;
                w_legal = 1'b0;
            end
        endcase
    end

    // Write pointer: base load wins over a request; legal accepts advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PTR_RESET;
        end else if (base_valid) begin
            r_wr_ptr <= base_addr;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        end else begin
            r_wr_ptr <= r_wr_ptr;
        end
    end

    // Sticky status: illegal mnemonic accepted, pointer wrapped past the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_illegal <= 1'b0;
            r_addr_wrap   <= 1'b0;
        end else begin
            if (w_accept && !w_legal) begin
                r_err_illegal <= 1'b1;
            end
            if (w_push && (r_wr_ptr == PTR_LAST)) begin
                r_addr_wrap <= 1'b1;
            end
        end
    end

    // Completed-write counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (w_pop && (r_instr_count != CNT_MAX)) begin
            r_instr_count <= r_instr_count + (ADDR_W+1)'(1);
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    enc_out_buf #(
        .AW (ADDR_W)
    ) u_out_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (r_wr_ptr),
        .i_push_data (w_word),
        .i_pop       (w_pop),
        .o_head_addr (imem_addr),
        .o_head_data (imem_wdata),
        .o_full      (w_buf_full),
        .o_empty     (w_buf_empty)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios with literal expectations plus a
// randomized phase, all scored every cycle against a queue-based model.
module tb_instr_encoder;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          base_valid;
    logic [AW-1:0] base_addr;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [4:0]    req_rs, req_rt, req_rd;
    logic [15:0]   req_imm;
    logic [25:0]   req_target;
    logic          imem_we;
    logic          imem_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   instr_count;
    logic          err_illegal;
    logic          addr_wrap;

    int errors = 0;
    int checks = 0;

    instr_encoder #(.ADDR_W(AW), .RESET_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .base_valid(base_valid), .base_addr(base_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
        .req_target(req_target), .imem_we(imem_we), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .instr_count(instr_count),
        .err_illegal(err_illegal), .addr_wrap(addr_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding straight from the instruction-format table.
    function automatic logic [31:0] enc_model(input int op, input int rs, input int rt,
                                              input int rd, input int imm, input int tgt,
                                              input int ptr);
        logic [4:0]  s, t, d;
        logic [15:0] i16;
        logic [25:0] t26;
        int          off;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0]; i16 = imm[15:0]; t26 = tgt[25:0];
        case (op)
            0:  return {6'h23, s, t, i16};
            1:  return {6'h2b, s, t, i16};
            2:  return {6'h02, t26};
            3:  return {6'h03, t26};
            4: begin
`ifdef ENC_BRANCH_REL_EN
                off = ((imm % 256) - (ptr + 1)) & 255;
                if (off >= 128) off = off - 256;
                i16 = off[15:0];
`else
                off = ptr;
`endif
                return {6'h05, s, t, i16};
            end
            5:  return {6'h08, s, t, i16};
            6:  return {6'h0e, s, t, i16};
            7:  return {6'h00, s, t, d, 5'd0, 6'h20};
            8:  return {6'h00, s, t, d, 5'd0, 6'h22};
            9:  return {6'h00, s, t, d, 5'd0, 6'h2a};
            10: return {6'h00, s, 5'd0, 5'd0, 5'd0, 6'h08};
            default: return 32'h0;
        endcase
    endfunction

    // Model state: pending writes as {addr, word}, pointer, counter, flags.
    logic [39:0] m_q[$];
    int          m_ptr, m_cnt;
    bit          m_err, m_wrap;

    // Compare process: check outputs against the model, then advance the model
    // with the inputs that the next rising edge will see.
    always @(negedge clk) begin
        bit acc, pop;
        if (!rst_n) begin
            m_q.delete();
            m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_wrap = 1'b0;
            chk("rst_we", imem_we, 1'b0);
            chk("rst_cnt", instr_count, 0);
            chk("rst_err", err_illegal, 1'b0);
            chk("rst_wrap", addr_wrap, 1'b0);
        end else begin
            chk("sb_we", imem_we, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("sb_addr", imem_addr, m_q[0][39:32]);
                chk("sb_data", imem_wdata, m_q[0][31:0]);
            end
            chk("sb_cnt", instr_count, m_cnt);
            chk("sb_err", err_illegal, m_err);
            chk("sb_wrap", addr_wrap, m_wrap);
            chk("sb_ready", req_ready, (m_q.size() < 2) && !base_valid);
            acc = req_valid && (m_q.size() < 2) && !base_valid;
            pop = (m_q.size() != 0) && imem_ready;
            if (pop) begin
                void'(m_q.pop_front());
                if (m_cnt < 2 * 256 - 1) m_cnt++;
            end
            if (base_valid) begin
                m_ptr = base_addr;
            end else if (acc) begin
                if (req_op <= 4'd10) begin
                    m_q.push_back({8'(m_ptr), enc_model(req_op, req_rs, req_rt, req_rd,
                                                       req_imm, req_target, m_ptr)});
                    if (m_ptr == 255) m_wrap = 1'b1;
                    m_ptr = (m_ptr + 1) % 256;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded wait).
    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int imm, input int tgt);
        int n;
        req_op = op[3:0]; req_rs = rs[4:0]; req_rt = rt[4:0]; req_rd = rd[4:0];
        req_imm = imm[15:0]; req_target = tgt[25:0]; req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; base_valid = 1'b0; base_addr = '0; req_valid = 1'b0;
        req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
        req_target = '0; imem_ready = 1'b1;
        #2 rst_n = 1'b0;
        tick(3);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        rst_n = 1'b1;
        tick(1);
        chk("rst_ready", req_ready, 1'b1);

        // Model pinned against hand-computed words.
        chk("model_add", enc_model(7, 1, 2, 3, 0, 0, 0), 32'h00221820);
        chk("model_lw", enc_model(0, 29, 8, 0, 4, 0, 0), 32'h8FA80004);

        // Basic encodings.
        send(7, 1, 2, 3, 0, 0);
        chk("add_addr", imem_addr, 0);
        chk("add_data", imem_wdata, 32'h00221820);
        tick(1);
        chk("add_cnt", instr_count, 1);
        send(0, 29, 8, 0, 4, 0);
        chk("lw_data", imem_wdata, 32'h8FA80004);
        send(3, 0, 0, 0, 0, 'h40);
        chk("jal_data", imem_wdata, 32'h0C000040);
        send(10, 31, 0, 0, 0, 0);
        chk("jr_data", imem_wdata, 32'h03E00008);
        tick(2);

        // Backpressure: two entries fill the buffer, third waits.
        imem_ready = 1'b0;
        send(7, 1, 2, 3, 0, 0);
        send(8, 4, 5, 6, 0, 0);
        @(negedge clk);
        chk("bp_ready", req_ready, 1'b0);
        chk("bp_head", imem_addr, 4);
        @(posedge clk); #1;
        imem_ready = 1'b1;
        send(9, 7, 8, 9, 0, 0);
        tick(3);

        // Illegal op: no write, sticky error, pointer untouched.
        send(15, 1, 1, 1, 0, 0);
        chk("ill_we", imem_we, 1'b0);
        chk("ill_err", err_illegal, 1'b1);
        send(7, 1, 2, 3, 0, 0);
        chk("ill_next_addr", imem_addr, 7);
        tick(2);

        // BNE with pointer at 5.
        base_valid = 1'b1; base_addr = 8'h05;
        tick(1);
        base_valid = 1'b0;
        send(4, 1, 2, 0, 2, 0);
        chk("bne_addr", imem_addr, 5);
`ifdef ENC_BRANCH_REL_EN
        chk("bne_data", imem_wdata, 32'h1422FFFC);
`else
        chk("bne_data", imem_wdata, 32'h14220002);
`endif
        tick(2);

        // Wrap from FF to 00.
        base_valid = 1'b1; base_addr = 8'hFF;
        tick(1);
        base_valid = 1'b0;
        chk("wrap_before", addr_wrap, 1'b0);
        send(7, 1, 2, 3, 0, 0);
        chk("wrap_addr_ff", imem_addr, 8'hFF);
        chk("wrap_flag", addr_wrap, 1'b1);
        send(5, 3, 4, 0, 'h1234, 0);
        chk("wrap_addr_00", imem_addr, 8'h00);
        tick(2);

        // Async reset mid-transfer.
        imem_ready = 1'b0;
        send(7, 1, 2, 3, 0, 0);
        chk("mid_we_before", imem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_we_after", imem_we, 1'b0);
        chk("mid_wrap", addr_wrap, 1'b0);
        chk("mid_err", err_illegal, 1'b0);
        chk("mid_cnt", instr_count, 0);
        tick(1);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        tick(1);

        // Randomized traffic, long enough to reach counter saturation.
        for (int c = 0; c < 1500; c++) begin
            req_valid  = ($urandom_range(0, 9) < 7);
            req_op     = ($urandom_range(0, 19) == 0) ? 4'(11 + $urandom_range(0, 4))
                                                      : 4'($urandom_range(0, 10));
            req_rs     = 5'($urandom); req_rt = 5'($urandom); req_rd = 5'($urandom);
            req_imm    = 16'($urandom); req_target = 26'($urandom);
            imem_ready = ($urandom_range(0, 9) < 8);
            base_valid = ($urandom_range(0, 49) == 0);
            base_addr  = 8'($urandom);
            tick(1);
        end
        req_valid = 1'b0; base_valid = 1'b0; imem_ready = 1'b1;
        tick(5);
        chk("end_drain", imem_we, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
